// File: rtl/pipelined_alu.sv
// Two-stage pipelined integer ALU: S1 registers the operation, S2 registers the result and NZCV flags.
// Both stages stall under output backpressure without dropping or duplicating operations.
module pipelined_alu #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags,
  output logic             busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  logic             s1_valid_q;
  logic [2:0]       s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_result_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic [3:0]       s2_flags_q;

  // A transfer happens on any edge where valid && ready; a stage may load
  // whenever it is empty or its own contents leave this cycle.
  logic adv1, adv2;
  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  logic [SHW-1:0]      shamt;
  logic [WIDTH:0]      add_ext, sub_ext, sll_ext, srl_ext;
  logic signed [WIDTH:0] sra_ext;
  logic [WIDTH-1:0]    result_d;
  logic                c_d, v_d;
  logic [3:0]          flags_d;

  // Shifts run one bit wider so the last bit shifted out lands in the spare bit.
  always_comb begin
    shamt    = s1_b_q[SHW-1:0];
    add_ext  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    sub_ext  = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + {{WIDTH{1'b0}}, 1'b1};
    sll_ext  = {1'b0, s1_a_q} << shamt;
    srl_ext  = {s1_a_q, 1'b0} >> shamt;
    sra_ext  = $signed({s1_a_q, 1'b0}) >>> shamt;
    result_d = '0;
    c_d      = 1'b0;
    v_d      = 1'b0;
    case (s1_op_q)
      OP_ADD: begin
        result_d = add_ext[WIDTH-1:0];
        c_d      = add_ext[WIDTH];
        v_d      = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (add_ext[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OP_SUB: begin
        result_d = sub_ext[WIDTH-1:0];
        c_d      = sub_ext[WIDTH];
        v_d      = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (sub_ext[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OP_AND: result_d = s1_a_q & s1_b_q;
      OP_XOR: result_d = s1_a_q ^ s1_b_q;
      OP_OR:  result_d = s1_a_q | s1_b_q;
      OP_SLL: begin
        result_d = sll_ext[WIDTH-1:0];
        c_d      = sll_ext[WIDTH];
      end
      OP_SRL: begin
        result_d = srl_ext[WIDTH:1];
        c_d      = srl_ext[0];
      end
      OP_SRA: begin
        result_d = sra_ext[WIDTH:1];
        c_d      = sra_ext[0];
      end
      default: result_d = '0;
    endcase
    flags_d = {result_d[WIDTH-1], (result_d == '0), c_d, v_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_op_q  <= in_op;
        s1_a_q   <= in_a;
        s1_b_q   <= in_b;
        s1_tag_q <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_tag_q    <= '0;
      s2_flags_q  <= '0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_result_q <= result_d;
        s2_tag_q    <= s1_tag_q;
        s2_flags_q  <= flags_d;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_tag    = s2_tag_q;
  assign out_flags  = s2_flags_q;
  assign busy       = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Bench for pipelined_alu: directed corner cases plus randomized traffic with backpressure,
// checked against an arithmetic reference model through an expected-result queue.
module tb_pipelined_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  in_op;
  logic [63:0] in_a, in_b, out_result;
  logic [4:0]  in_tag, out_tag;
  logic [3:0]  out_flags;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [2:0]  in_op8;
  logic [7:0]  in_a8, in_b8, out_result8;
  logic [4:0]  in_tag8, out_tag8;
  logic [3:0]  out_flags8;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pops   = 0;
  bit popped;
  logic [72:0] exp_q[$];

  pipelined_alu #(.WIDTH(64), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_flags(out_flags), .busy(busy)
  );

  pipelined_alu #(.WIDTH(8), .TAG_W(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_op(in_op8), .in_a(in_a8), .in_b(in_b8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_result(out_result8),
    .out_tag(out_tag8), .out_flags(out_flags8), .busy(busy8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference: flags and result from the arithmetic definitions, shifts done one bit at a time.
  function automatic logic [67:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic c, v;
    logic signed [65:0] exact;
    int n;
    r = '0; c = 1'b0; v = 1'b0; exact = '0;
    n = int'(b[5:0]);
    case (op)
      3'd0: begin
        r = a + b;
        c = (r < a);
        exact = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
        v = (exact != $signed({{2{r[63]}}, r}));
      end
      3'd1: begin
        r = a - b;
        c = (a >= b);
        exact = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
        v = (exact != $signed({{2{r[63]}}, r}));
      end
      3'd2: r = a & b;
      3'd3: r = a ^ b;
      3'd4: r = a | b;
      3'd5: begin r = a; for (int i = 0; i < n; i++) begin c = r[63]; r = {r[62:0], 1'b0}; end end
      3'd6: begin r = a; for (int i = 0; i < n; i++) begin c = r[0]; r = {1'b0, r[63:1]}; end end
      default: begin r = a; for (int i = 0; i < n; i++) begin c = r[0]; r = {r[63], r[63:1]}; end end
    endcase
    return {r[63], (r == 64'd0), c, v, r};
  endfunction

  // One cycle: sample handshakes just after the falling edge, then wait for the next one.
  task automatic tick(output bit acc);
    logic [72:0] e;
    #1;
    acc = in_valid && in_ready;
    popped = 1'b0;
    if (acc) exp_q.push_back({in_tag, model(in_op, in_a, in_b)});
    if (out_valid && out_ready) begin
      popped = 1'b1;
      pops++;
      if (exp_q.size() == 0) check("unexpected_output", out_valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        check("out_tag", out_tag, e[72:68]);
        check("out_flags", out_flags, e[67:64]);
        check("out_result", out_result, e[63:0]);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic rand_op(input logic [4:0] tag);
    logic [31:0] r;
    r = $urandom;
    in_op = r[2:0];
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    if (r[5:3] == 3'd0) in_b = in_a;
    if (r[8:6] == 3'd0) in_a = 64'h8000_0000_0000_0000;
    if (r[11:9] == 3'd0) in_a = 64'h7FFF_FFFF_FFFF_FFFF;
    in_tag = tag;
  endtask

  task automatic directed(input string name, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag,
                          input logic [63:0] exp_r, input logic [3:0] exp_f);
    bit acc;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = 1'b1;
    tick(acc);
    check({name, "_accept"}, acc, 1'b1);
    in_valid = 1'b0;
    #1 check({name, "_valid_c1"}, out_valid, 1'b0);
    tick(acc);
    #1;
    check({name, "_valid_c2"}, out_valid, 1'b1);
    check({name, "_result"}, out_result, exp_r);
    check({name, "_tag"}, out_tag, tag);
    check({name, "_flags"}, out_flags, exp_f);
    tick(acc);
  endtask

  task automatic directed8(input string name, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp_r, input logic [3:0] exp_f);
    in_valid8 = 1'b1; in_op8 = op; in_a8 = a; in_b8 = b; in_tag8 = 5'd1; out_ready8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    @(negedge clk);
    #1;
    check({name, "_valid"}, out_valid8, 1'b1);
    check({name, "_result"}, out_result8, exp_r);
    check({name, "_flags"}, out_flags8, exp_f);
    @(negedge clk);
  endtask

  initial begin
    bit acc;
    int k, pops0, first_c, last_c;
    logic [4:0] next_tag;

    rst_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_op8 = '0; in_a8 = '0; in_b8 = '0; in_tag8 = '0; out_ready8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result", out_result, 64'd0);
    check("rst_tag", out_tag, 5'd0);
    check("rst_flags", out_flags, 4'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid8", out_valid8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    directed("add_ovf", 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd3, 64'h8000_0000_0000_0000, 4'b1001);
    directed("sub_eq", 3'd1, 64'd5, 64'd5, 5'd4, 64'd0, 4'b0110);
    directed("sub_borrow", 3'd1, 64'd0, 64'd1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
    directed("sra", 3'd7, 64'h8000_0000_0000_0000, 64'd4, 5'd6, 64'hF800_0000_0000_0000, 4'b1000);
    directed("sll", 3'd5, 64'h8000_0000_0000_0001, 64'd1, 5'd7, 64'd2, 4'b0010);
    directed("srl_zero", 3'd6, 64'hDEAD_BEEF_0123_4567, 64'd64, 5'd8, 64'hDEAD_BEEF_0123_4567, 4'b1000);

    // Back-to-back stream: eight results on eight consecutive cycles.
    pops0 = pops; first_c = -1; last_c = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin in_valid = 1'b1; rand_op(i[4:0]); end
      else in_valid = 1'b0;
      tick(acc);
      if (i < 8) check("stream_accept", acc, 1'b1);
      if (popped) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
    end
    check("stream_count", pops - pops0, 8);
    check("stream_first_latency", first_c - (cyc - 12), 3);
    check("stream_span", last_c - first_c, 7);

    // Backpressure: with out_ready low only two of three offers are taken.
    out_ready = 1'b0; k = 0;
    in_valid = 1'b1; rand_op(5'd10);
    for (int i = 0; i < 4; i++) begin
      tick(acc);
      if (acc) begin k++; rand_op(5'(10 + k)); end
    end
    check("stall_accepted", k, 2);
    #1;
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_busy", busy, 1'b1);
    check("stall_out_valid", out_valid, 1'b1);
    check("stall_result_a", out_result, exp_q[0][63:0]);
    tick(acc);
    check("stall_no_accept", acc, 1'b0);
    #1 check("stall_result_b", out_result, exp_q[0][63:0]);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(acc);
      if (acc) begin k++; in_valid = 1'b0; end
    end
    check("stall_total_accepted", k, 3);
    check("stall_drained", exp_q.size(), 0);

    // Randomized traffic with random valid and ready.
    next_tag = 5'd0;
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_op(next_tag);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
      if (acc) begin next_tag = next_tag + 5'd1; in_valid = 1'b0; end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick(acc);
    check("random_drained", exp_q.size(), 0);

    // Reset while both stages are full and stalled.
    out_ready = 1'b0; in_valid = 1'b1; rand_op(5'd20);
    for (int i = 0; i < 3; i++) tick(acc);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_result", out_result, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(acc);
      check("postrst_busy", busy, 1'b0);
    end

    directed8("add8_ovf", 3'd0, 8'h7F, 8'h01, 8'h80, 4'b1001);
    directed8("sub8_borrow", 3'd1, 8'h00, 8'h01, 8'hFF, 4'b1000);
    directed8("srl8", 3'd6, 8'h81, 8'd1, 8'h40, 4'b0010);

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
